trigger_frame_scheduler: RTL and testbench



---
 rtl/trigger_frame_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/trigger_frame_scheduler.sv | 134 +++++++++++++
 tb/tb_trigger_frame_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_frame_pkg.sv
// Shared constants for the 10-byte trigger frame: delimiters, byte positions and frame state.
package trigger_frame_pkg;

    localparam logic [7:0] SOP = 8'h3C;
    localparam logic [7:0] EOP = 8'hBC;
    localparam int FRAME_LENGTH = 10;

    localparam logic [3:0] IDX_SOP     = 4'd0;
    localparam logic [3:0] IDX_STATUS  = 4'd1;
    localparam logic [3:0] IDX_ADDR_HI = 4'd2;
    localparam logic [3:0] IDX_ADDR_LO = 4'd3;
    localparam logic [3:0] IDX_DATA0   = 4'd4;
    localparam logic [3:0] IDX_DATA1   = 4'd5;
    localparam logic [3:0] IDX_DATA2   = 4'd6;
    localparam logic [3:0] IDX_DATA3   = 4'd7;
    localparam logic [3:0] IDX_CRC     = 4'd8;
    localparam logic [3:0] IDX_EOP     = 4'd9;

    // Grant indices are carried in 3 bits so up to 8 requesters fit.
    localparam int GRANT_W = 3;
    localparam int SLOTS   = 1 << GRANT_W;

    typedef enum logic {
        IDLE_FRAME = 1'b0,
        REQ_FRAME  = 1'b1
    } frame_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search begins one past the previous winner.
// Optional REQ0_PRIORITY_EN gives requester 0 absolute priority.
module rr_arbiter
    import trigger_frame_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [GRANT_W-1:0] last_grant_i,
    input  logic               enable_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [GRANT_W-1:0] grant_idx_o
);

    logic [SLOTS-1:0]   req_pad;
    logic [GRANT_W-1:0] cand;
    logic               found;

    assign req_pad = SLOTS'(req_i);

    always_comb begin
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = GRANT_W'((int'(last_grant_i) + 1 + k) % NUM_REQ);
            if (!found && req_pad[cand]) begin
                found       = 1'b1;
                grant_idx_o = cand;
            end
        end
`ifdef REQ0_PRIORITY_EN
        if (req_i[0]) begin
            grant_idx_o = '0;
        end
`endif
        grant_o = '0;
        if (enable_i && found) begin
            grant_o = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_o;
        end
    end

endmodule

// File: rtl/trigger_frame_scheduler.sv
// Fills the fixed 10-byte trigger frame slot with idle frames or one arbitrated command.
// Build option: define REQ0_PRIORITY_EN to let requester 0 pre-empt round-robin.
module trigger_frame_scheduler
    import trigger_frame_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*16-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0] req_data,
    output logic [NUM_REQ-1:0]    ack,
    output logic [2:0]            grant_id,
    output logic                  frame_is_req,
    output logic [7:0]            data,
    output logic                  is_control_byte,
    output logic                  is_crc_byte,
    output logic                  crc_reset
);

    logic [3:0]         idx_q, idx_d;
    frame_state_e       state_q, state_d;
    logic [6:0]         seq_q, seq_d;
    logic [GRANT_W-1:0] last_grant_q, last_grant_d;
    logic [GRANT_W-1:0] grant_id_q, grant_id_d;
    logic [15:0]        addr_q, addr_d;
    logic [31:0]        word_q, word_d;

    logic               arb_en;
    logic               req_any;
    logic [GRANT_W-1:0] win_idx;
    logic [15:0]        addr_slot [SLOTS];
    logic [31:0]        word_slot [SLOTS];

    // Pad the per-requester buses out to a power-of-two table so the winner index selects cleanly.
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
        if (gi < NUM_REQ) begin : g_used
            assign addr_slot[gi] = req_addr[16*gi +: 16];
            assign word_slot[gi] = req_data[32*gi +: 32];
        end else begin : g_pad
            assign addr_slot[gi] = '0;
            assign word_slot[gi] = '0;
        end
    end

    assign arb_en  = (idx_q == IDX_EOP);
    assign req_any = |req;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req_i       (req),
        .last_grant_i(last_grant_q),
        .enable_i    (arb_en),
        .grant_o     (ack),
        .grant_idx_o (win_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q        <= IDX_SOP;
            state_q      <= IDLE_FRAME;
            seq_q        <= '0;
            last_grant_q <= GRANT_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            addr_q       <= '0;
            word_q       <= '0;
        end else begin
            idx_q        <= idx_d;
            state_q      <= state_d;
            seq_q        <= seq_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            addr_q       <= addr_d;
            word_q       <= word_d;
        end
    end

    always_comb begin
        idx_d        = (idx_q == IDX_EOP) ? IDX_SOP : idx_q + 4'd1;
        state_d      = state_q;
        seq_d        = seq_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        addr_d       = addr_q;
        word_d       = word_q;
        if (arb_en) begin
            if (state_q == REQ_FRAME) begin
                seq_d = seq_q + 7'd1;
            end
            if (req_any) begin
                state_d    = REQ_FRAME;
                grant_id_d = win_idx;
                addr_d     = addr_slot[win_idx];
                word_d     = word_slot[win_idx];
`ifdef REQ0_PRIORITY_EN
                // Priority grants to requester 0 leave the rotation of the others untouched.
                if (win_idx != '0) begin
                    last_grant_d = win_idx;
                end
`else
                last_grant_d = win_idx;
`endif
            end else begin
                state_d    = IDLE_FRAME;
                grant_id_d = '0;
            end
        end
    end

    assign frame_is_req    = (state_q == REQ_FRAME);
    assign grant_id        = grant_id_q;
    assign is_control_byte = (idx_q == IDX_SOP) || (idx_q == IDX_EOP);
    assign is_crc_byte     = (idx_q == IDX_CRC);
    assign crc_reset       = (idx_q == IDX_SOP);

    always_comb begin
        data = 8'h00;
        case (idx_q)
            IDX_SOP:     data = SOP;
            IDX_STATUS:  data = frame_is_req ? {1'b1, seq_q} : 8'h00;
            IDX_ADDR_HI: data = frame_is_req ? addr_q[15:8]  : 8'h00;
            IDX_ADDR_LO: data = frame_is_req ? addr_q[7:0]   : 8'h00;
            IDX_DATA0:   data = frame_is_req ? word_q[31:24] : 8'h00;
            IDX_DATA1:   data = frame_is_req ? word_q[23:16] : 8'h00;
            IDX_DATA2:   data = frame_is_req ? word_q[15:8]  : 8'h00;
            IDX_DATA3:   data = frame_is_req ? word_q[7:0]   : 8'h00;
            IDX_EOP:     data = EOP;
            default:     data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_trigger_frame_scheduler.sv
// Directed bench for trigger_frame_scheduler; outputs are sampled on the falling clock edge.
module tb_trigger_frame_scheduler;

    localparam int NUM_REQ = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*16-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_data;
    logic [NUM_REQ-1:0]    ack;
    logic [2:0]            grant_id;
    logic                  frame_is_req;
    logic [7:0]            data;
    logic                  is_control_byte;
    logic                  is_crc_byte;
    logic                  crc_reset;

    int tests_run    = 0;
    int tests_failed = 0;

    trigger_frame_scheduler #(.NUM_REQ(NUM_REQ)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .ack            (ack),
        .grant_id       (grant_id),
        .frame_is_req   (frame_is_req),
        .data           (data),
        .is_control_byte(is_control_byte),
        .is_crc_byte    (is_crc_byte),
        .crc_reset      (crc_reset)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench one time unit after release, i.e. sampling idx 0 of an idle frame.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req   = '0;
        step(2);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        logic [18:0] got, exp;
        step(3);
        reset = 1'b0;
        #1;
        got = {ack, data, is_control_byte, is_crc_byte, crc_reset, frame_is_req, grant_id};
        exp = {4'b0000, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
        tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL reset_state: got %h expected %h", got, exp); end
        step(2);
        reset = 1'b1;
        #1;
        $display("[TB] reset state checked");
    endtask

    task automatic test_idle();
        logic [18:0] got, exp;
        logic [7:0]  b;
        int i;
        for (int c = 0; c < 20; c++) begin
            i = c % 10;
            b = (i == 0) ? 8'h3C : (i == 9) ? 8'hBC : 8'h00;
            got = {ack, data, is_control_byte, is_crc_byte, crc_reset, frame_is_req, grant_id};
            exp = {4'b0000, b, (i == 0 || i == 9), (i == 8), (i == 0), 1'b0, 3'd0};
            tests_run++;
            if (got !== exp) begin tests_failed++; $display("FAIL idle_byte%0d: got %h expected %h", i, got, exp); end
            step(1);
        end
        $display("[TB] idle stream: 2 frames checked");
    endtask

    task automatic test_single();
        logic [7:0]  fr [10];
        logic [18:0] got, exp;
        fr = '{8'h3C, 8'h80, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'hBC};
        do_reset();
        step(3);
        req = 4'b0010;
        req_addr[31:16] = 16'h1234;
        req_data[63:32] = 32'hDEADBEEF;
        for (int c = 4; c < 10; c++) begin
            step(1);
            tests_run++;
            if (ack !== ((c == 9) ? 4'b0010 : 4'b0000)) begin
                tests_failed++; $display("FAIL single_ack_idx%0d: got %b expected %b", c, ack, (c == 9) ? 4'b0010 : 4'b0000);
            end
        end
        step(1);
        req = '0;
        for (int i = 0; i < 10; i++) begin
            got = {ack, data, is_control_byte, is_crc_byte, crc_reset, frame_is_req, grant_id};
            exp = {4'b0000, fr[i], (i == 0 || i == 9), (i == 8), (i == 0), 1'b1, 3'd1};
            tests_run++;
            if (got !== exp) begin tests_failed++; $display("FAIL single_byte%0d: got %h expected %h", i, got, exp); end
            step(1);
        end
        for (int i = 0; i < 10; i++) begin
            exp = {4'b0000, (i == 0) ? 8'h3C : (i == 9) ? 8'hBC : 8'h00, (i == 0 || i == 9), (i == 8), (i == 0), 1'b0, 3'd0};
            got = {ack, data, is_control_byte, is_crc_byte, crc_reset, frame_is_req, grant_id};
            tests_run++;
            if (got !== exp) begin tests_failed++; $display("FAIL single_idle_byte%0d: got %h expected %h", i, got, exp); end
            step(1);
        end
        $display("[TB] single request frame checked");
    endtask

    task automatic test_round_robin();
        logic [2:0]  g;
        logic [3:0]  exp_ack;
        do_reset();
        req      = 4'b1111;
        req_addr = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        req_data = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
        step(9);
        tests_run++;
        if (ack !== 4'b0001) begin tests_failed++; $display("FAIL rr_first_ack: got %b expected 0001", ack); end
        step(1);
        for (int f = 0; f < 5; f++) begin
            g = 3'(f % 4);
            step(1);
            tests_run++;
            if ({frame_is_req, grant_id, data} !== {1'b1, g, 8'h80 + 8'(f)}) begin
                tests_failed++; $display("FAIL rr_frame%0d_status: got %h expected %h", f, {frame_is_req, grant_id, data}, {1'b1, g, 8'h80 + 8'(f)});
            end
            step(2);
            tests_run++;
            if (data !== 8'(g)) begin tests_failed++; $display("FAIL rr_frame%0d_addr_lo: got %h expected %h", f, data, 8'(g)); end
            step(6);
            exp_ack = 4'b0001 << ((f + 1) % 4);
            tests_run++;
            if (ack !== exp_ack) begin tests_failed++; $display("FAIL rr_frame%0d_ack: got %b expected %b", f, ack, exp_ack); end
            step(1);
        end
        req = '0;
        $display("[TB] round-robin: 5 frames checked");
    endtask

    task automatic test_seq_wrap();
        logic [7:0] exp;
        do_reset();
        req = 4'b0001;
        step(10);
        for (int f = 0; f < 129; f++) begin
            exp = {1'b1, 7'(f)};
            step(1);
            tests_run++;
            if (data !== exp) begin tests_failed++; $display("FAIL seq_frame%0d: got %h expected %h", f, data, exp); end
            step(9);
        end
        req = '0;
        $display("[TB] sequence wrap: 129 frames checked");
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        do_reset();
        req = 4'b0100;
        step(20);
        step(1);
        tests_run++;
        if (data !== 8'h81) begin tests_failed++; $display("FAIL mid_pre_status: got %h expected 81", data); end
        step(4);
        tests_run++;
        if ({frame_is_req, grant_id} !== {1'b1, 3'd2}) begin
            tests_failed++; $display("FAIL mid_pre_grant: got %h expected %h", {frame_is_req, grant_id}, {1'b1, 3'd2});
        end
        reset = 1'b0;
        req   = '0;
        #1;
        tests_run++;
        if ({data, ack, frame_is_req, grant_id} !== {8'h3C, 4'b0000, 1'b0, 3'd0}) begin
            tests_failed++; $display("FAIL mid_in_reset: got %h expected %h", {data, ack, frame_is_req, grant_id}, {8'h3C, 4'b0000, 1'b0, 3'd0});
        end
        step(2);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            b = (i == 0) ? 8'h3C : (i == 9) ? 8'hBC : 8'h00;
            tests_run++;
            if ({data, frame_is_req} !== {b, 1'b0}) begin
                tests_failed++; $display("FAIL mid_idle_byte%0d: got %h expected %h", i, {data, frame_is_req}, {b, 1'b0});
            end
            step(1);
        end
        req = 4'b0100;
        step(9);
        tests_run++;
        if (ack !== 4'b0100) begin tests_failed++; $display("FAIL mid_post_ack: got %b expected 0100", ack); end
        step(2);
        req = '0;
        tests_run++;
        if (data !== 8'h80) begin tests_failed++; $display("FAIL mid_post_status: got %h expected 80", data); end
        $display("[TB] reset mid-frame checked");
    endtask

    task automatic test_priority();
        logic [2:0] exp_g [5];
        logic [3:0] exp_ack;
`ifdef REQ0_PRIORITY_EN
        exp_g = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
`else
        exp_g = '{3'd0, 3'd2, 3'd0, 3'd2, 3'd0};
`endif
        do_reset();
        req = 4'b0101;
        step(9);
        tests_run++;
        if (ack !== 4'b0001) begin tests_failed++; $display("FAIL prio_first_ack: got %b expected 0001", ack); end
        step(1);
        for (int f = 0; f < 4; f++) begin
            step(1);
            tests_run++;
            if (grant_id !== exp_g[f]) begin tests_failed++; $display("FAIL prio_frame%0d_grant: got %0d expected %0d", f, grant_id, exp_g[f]); end
            step(8);
            exp_ack = 4'b0001 << exp_g[f+1];
            tests_run++;
            if (ack !== exp_ack) begin tests_failed++; $display("FAIL prio_frame%0d_ack: got %b expected %b", f, ack, exp_ack); end
            step(1);
        end
        req = '0;
        $display("[TB] priority option: 4 frames checked");
    endtask

    initial begin
        reset    = 1'b0;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        step(2);
        reset = 1'b1;
        #1;
        test_reset();
        test_idle();
        test_single();
        test_round_robin();
        test_seq_wrap();
        test_reset_mid();
        test_priority();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
